// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//
// Deterministic rate encoder. A frame of N_CH pixel intensities is converted
// into T_STEPS binary spike vectors, one per `pulse` timestep. Each channel
// runs a first-order sigma-delta accumulator, so the number of spikes on
// channel i over a frame is exactly floor(T_STEPS * inten[i] / 2^PIX_W).
// A frame spans T_STEPS generating pulses plus one drain pulse. The drain
// pulse clears the outputs and raises frame_done for one cycle.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low reset
//   pix_valid  - frame intensities present on pix_data
//   pix_ready  - encoder can accept a frame (state == IDLE)
//   pix_data   - N_CH intensities, channel i at [i*PIX_W +: PIX_W]
//   pulse      - one-cycle timestep strobe shared with the downstream layer
//   spk_out    - registered spike vector (downstream pixelsIn)
//   spk_valid  - high while spk_out carries a frame timestep
//   frame_done - one-cycle strobe after the drain pulse

module spike_rate_encoder #(
    parameter int N_CH    = 5,
    parameter int PIX_W   = 8,
    parameter int T_STEPS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [N_CH*PIX_W-1:0]   pix_data,
    input  logic                    pulse,
    output logic [N_CH-1:0]         spk_out,
    output logic                    spk_valid,
    output logic                    frame_done
);

    localparam int STEP_W = $clog2(T_STEPS) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [PIX_W-1:0]    inten [N_CH];
    logic [PIX_W-1:0]    acc   [N_CH];
    logic [PIX_W:0]      sum   [N_CH];
    logic [STEP_W-1:0]   step;

    assign pix_ready = (state == IDLE);

    // Accumulator plus intensity; the carry bit is the spike for this step.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inten[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            step       <= '0;
            spk_out    <= '0;
            spk_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                inten[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A pulse here (even one coincident with the load) is
                    // ignored; the first counted step is the next pulse.
                    if (pix_valid) begin
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            inten[i] <= pix_data[i*PIX_W +: PIX_W];
                            acc[i]   <= '0;
                        end
                        step  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (pulse) begin
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            acc[i]     <= sum[i][PIX_W-1:0];
                            spk_out[i] <= sum[i][PIX_W];
                        end
                        spk_valid <= 1'b1;
                        step      <= step + STEP_W'(1);
                        if (step == LAST_STEP) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last vector is held until this pulse so the downstream
                    // layer, sampling one pulse late, sees all T_STEPS vectors.
                    if (pulse) begin
                        spk_out    <= '0;
                        spk_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Deterministic rate encoder that turns a frame of pixel intensities into per-timestep binary spike vectors. It is the producer for the spiking layer's `pixelsIn` bus: one spike vector per timestep `pulse`, which the MAC/NCHU layer consumes on the same `pulse`. Each channel uses a first-order sigma-delta accumulator, so spike counts are exact and repeatable; there is no randomness.

## Interface
Parameters:
- `N_CH`, 5: number of pixel channels (spike vector width).
- `PIX_W`, 8: intensity width per channel; accumulator width.
- `T_STEPS`, 16: timesteps per frame; legal range 2..256.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `pix_valid` input 1: frame intensities present on `pix_data`.
- `pix_ready` output 1: encoder can accept a frame; equals (state == IDLE).
- `pix_data` input N_CH*PIX_W: channel i is at bits [i*PIX_W +: PIX_W].
- `pulse` input 1: one-cycle timestep strobe, shared with the downstream layer.
- `spk_out` output N_CH: registered spike vector, drives downstream `pixelsIn`.
- `spk_valid` output 1: high while `spk_out` carries a frame timestep.
- `frame_done` output 1: one-cycle strobe at the end of a frame.

## Operation
- State is held in the following registers:
  - `inten[N_CH]`, PIX_W bits each.
  - `acc[N_CH]`, PIX_W bits each.
  - `step`, a counter of $clog2(T_STEPS)+1 bits.
  - A state register with three states: IDLE, RUN, DRAIN.
- IDLE behaviour:
  - `pix_ready`=1 and `spk_out`=0.
  - A `pulse` in IDLE is ignored.
  - On `pix_valid` & `pix_ready`: capture `pix_data` into `inten`, clear every `acc` to 0, clear `step` to 0, and go to RUN.
  - If `pulse` arrives in the same cycle as the load, it is not counted.
- RUN behaviour, on each cycle with `pulse`=1, for every channel i:
  - Compute the (PIX_W+1)-bit sum `acc[i] + inten[i]`.
  - `acc[i]` takes the low PIX_W bits of the sum.
  - `spk_out[i]` takes the carry bit.
  - `step` increments.
  - If `step` was T_STEPS-1, go to DRAIN.
- Spike count over a frame for channel i is exactly floor(T_STEPS*inten[i]/2^PIX_W).
  - Intensity 0 gives no spikes.
  - Intensity 2^PIX_W-1 gives T_STEPS-1 spikes.
- DRAIN behaviour:
  - `spk_out` holds the last vector until the next `pulse`.
  - On that pulse: `spk_out`, `spk_valid` and `frame_done` are all registered in the same edge.
    - `spk_out` is cleared to 0.
    - `spk_valid` is cleared.
    - `frame_done`=1 for exactly one cycle.
  - The state goes to IDLE on that same edge.
  - This guarantees the downstream layer samples all T_STEPS vectors.
- `spk_valid` is registered.
  - It is set on the first RUN pulse.
  - It is cleared on the DRAIN-exit pulse.
- `pix_valid` outside IDLE is ignored, and `inten` stays unchanged.
- Between pulses all registers hold. Arbitrary pulse spacing is legal, including pulses on back-to-back cycles.

## Timing
- Reset values:
  - State is IDLE, so `pix_ready`=1, including while `reset` is asserted.
  - `spk_out`=0, `spk_valid`=0, `frame_done`=0.
  - `acc`=0, `inten`=0, `step`=0.
- Load latency:
  - The accepting edge moves the state to RUN.
  - `pix_ready` falls in the next cycle.
- Pulse to output:
  - `spk_out` changes at the edge on which `pulse` is sampled.
  - A downstream register clocked on pulse k therefore sees the vector generated at pulse k-1.
  - One frame spans T_STEPS+1 pulses: T_STEPS generating pulses plus 1 drain pulse.
- `frame_done` is high in the cycle after the drain pulse edge.
  - `pix_ready` is already 1 in that cycle.
  - A new frame may load in that same cycle.
- Reset mid-frame, in any state:
  - Outputs return to reset values immediately (asynchronous).
  - No `frame_done` is generated.
  - A partial frame is discarded.
- Minimum frame length is T_STEPS+1 pulses, plus 1 load cycle.

## Test plan
1. Reset check.
   - Stimulus: assert `reset`=0 mid-simulation with random inputs.
   - Required: `spk_out`=0, `spk_valid`=0, `frame_done`=0, `pix_ready`=1.
2. Exact counts.
   - Stimulus: load intensities {0,255,128,64,16} with T_STEPS=16, then apply 17 pulses.
   - Required:
     - Per-channel spike counts are {0,15,8,4,1}.
     - Channel 2 (128) spikes on steps 2,4,…,16.
     - Channel 4 (16) spikes only on step 16.
3. Frame boundary.
   - Required:
     - After pulse 16, `spk_out` holds the step-16 vector until pulse 17.
     - At pulse 17: `spk_out`=0, `spk_valid`=0, and `frame_done` is high for one cycle.
     - `pix_ready`=1 in that same cycle.
     - A second frame loaded in that cycle starts cleanly, with `acc`=0.
4. Ignored inputs.
   - Stimulus: pulses in IDLE, `pix_valid` with new data during RUN, and `pulse` coincident with the load.
   - Required:
     - No output change while in IDLE.
     - `inten` unchanged.
     - The coincident pulse does not consume a step; counts are as in test 2.
5. Irregular pulses.
   - Stimulus: pulse gaps randomized from 1 to 20 cycles, including back-to-back pulses.
   - Required: spike sequence identical to test 2, with outputs stable between pulses.
6. Mid-frame reset.
   - Stimulus: assert reset after pulse 7, then release it.
   - Required:
     - Immediate reset values.
     - No `frame_done`.
     - The next loaded frame reproduces test 2 exactly.
